// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, issues req/ack fetches and queues {PC, instr} for decode.
// Optional misaligned-redirect trap and HALT state are built when FETCH_MISALIGN_TRAP_EN is defined.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        redirect,
   input  logic [31:0] redirectPC,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemAck,
   input  logic [31:0] imemData,
   output logic        instValid,
   output logic [31:0] instPC,
   output logic [31:0] instData,
   input  logic        instReady,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic        misalignTrap,
`endif
   output logic [31:0] curPC
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DISCARD
`ifdef FETCH_MISALIGN_TRAP_EN
      , HALT
`endif
   } state_t;

   state_t          state_q, state_d, resume_st;
   logic [31:0]     cur_pc_q, cur_pc_d;
   logic [31:0]     addr_q, addr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d, count_after;
   logic            head_valid_q, head_valid_d;
   logic [31:0]     head_pc_q, head_pc_d, head_data_q, head_data_d;
   logic [31:0]     mem_pc   [DEPTH];
   logic [31:0]     mem_data [DEPTH];
   logic [31:0]     target_pc;
   logic            pop, push;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic trap_q, trap_d;
   assign target_pc    = redirectPC;
   assign misalignTrap = trap_q;
`else
   assign target_pc = {redirectPC[31:2], 2'b00};
`endif

   // A redirect cancels both the consumer pop and any push of returning data.
   assign pop         = head_valid_q & instReady & ~redirect;
   assign push        = (state_q == REQ) & imemAck & ~redirect;
   assign count_after = count_q + CW'(push) - CW'(pop);

   always_comb begin
      state_d   = state_q;
      cur_pc_d  = cur_pc_q;
      addr_d    = addr_q;
      resume_st = REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_d = trap_q;
      if (redirect) trap_d = (redirectPC[1:0] != 2'b00);
      if (trap_d) resume_st = HALT;
`endif
      if (redirect) cur_pc_d = target_pc;
      case (state_q)
         IDLE: if (redirect || count_after < DEPTH_C) state_d = resume_st;
         REQ: begin
            if (imemAck) begin
               if (redirect) begin
                  state_d = resume_st;
               end else begin
                  cur_pc_d = cur_pc_q + 32'd4;
                  state_d  = (count_after < DEPTH_C) ? REQ : IDLE;
               end
            end else if (redirect) begin
               state_d = DISCARD;
            end
         end
         // The outstanding request must complete before anything new is issued.
         DISCARD: if (imemAck) state_d = resume_st;
`ifdef FETCH_MISALIGN_TRAP_EN
         HALT: if (redirect && !trap_d) state_d = REQ;
`endif
         default: state_d = IDLE;
      endcase
      if (state_d == REQ) addr_d = cur_pc_d;
   end

   always_comb begin
      count_d      = redirect ? '0 : count_after;
      rd_ptr_d     = redirect ? '0 : rd_ptr_q + PW'(pop);
      wr_ptr_d     = redirect ? '0 : wr_ptr_q + PW'(push);
      head_valid_d = (count_d != '0);
      head_pc_d    = head_pc_q;
      head_data_d  = head_data_q;
      // Head becomes the incoming word when it lands directly at the read pointer.
      if (count_d != '0) begin
         if (push && wr_ptr_q == rd_ptr_d) begin
            head_pc_d   = addr_q;
            head_data_d = imemData;
         end else begin
            head_pc_d   = mem_pc[rd_ptr_d];
            head_data_d = mem_data[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         mem_pc[wr_ptr_q]   <= addr_q;
         mem_data[wr_ptr_q] <= imemData;
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q      <= IDLE;
         cur_pc_q     <= RESET_PC;
         addr_q       <= RESET_PC;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         head_valid_q <= 1'b0;
         head_pc_q    <= '0;
         head_data_q  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
         trap_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cur_pc_q     <= cur_pc_d;
         addr_q       <= addr_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         head_valid_q <= head_valid_d;
         head_pc_q    <= head_pc_d;
         head_data_q  <= head_data_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         trap_q       <= trap_d;
`endif
      end
   end

   assign imemReq   = (state_q == REQ) || (state_q == DISCARD);
   assign imemAddr  = addr_q;
   assign instValid = head_valid_q;
   assign instPC    = head_pc_q;
   assign instData  = head_data_q;
   assign curPC     = cur_pc_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit against a transaction-level model (queue + outstanding request).
module tb_inst_fetch_unit;

   localparam int DEPTH = 2;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        redirect;
   logic [31:0] redirectPC;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck;
   logic [31:0] imemData;
   logic        instValid;
   logic [31:0] instPC;
   logic [31:0] instData;
   logic        instReady;
   logic [31:0] curPC;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalignTrap;
`endif

   inst_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
      .CLK(CLK),
      .Reset(Reset),
      .redirect(redirect),
      .redirectPC(redirectPC),
      .imemReq(imemReq),
      .imemAddr(imemAddr),
      .imemAck(imemAck),
      .imemData(imemData),
      .instValid(instValid),
      .instPC(instPC),
      .instData(instData),
      .instReady(instReady),
`ifdef FETCH_MISALIGN_TRAP_EN
      .misalignTrap(misalignTrap),
`endif
      .curPC(curPC)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cycle, got, exp);
      end
   endtask

   // Reference model: instruction queue, PC, and at most one outstanding memory request.
   logic [63:0] m_fifo [$];
   logic [31:0] m_cur_pc   = 32'h0;
   logic        m_req_act  = 1'b0;
   logic [31:0] m_req_addr = 32'h0;
   logic        m_req_drop = 1'b0;
   logic        m_trap     = 1'b0;

   task automatic check_outputs();
      check_eq("imemReq", 32'(imemReq), 32'(m_req_act));
      if (m_req_act) check_eq("imemAddr", imemAddr, m_req_addr);
      check_eq("instValid", 32'(instValid), 32'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) begin
         check_eq("instPC", instPC, m_fifo[0][63:32]);
         check_eq("instData", instData, m_fifo[0][31:0]);
      end
      check_eq("curPC", curPC, m_cur_pc);
`ifdef FETCH_MISALIGN_TRAP_EN
      check_eq("misalignTrap", 32'(misalignTrap), 32'(m_trap));
`endif
   endtask

   task automatic model_step();
      logic [31:0] rpc;
      logic        pop, completing, push;
      rpc = redirectPC;
`ifndef FETCH_MISALIGN_TRAP_EN
      rpc[1:0] = 2'b00;
`endif
      pop        = (m_fifo.size() > 0) && instReady && !redirect;
      completing = m_req_act && imemAck;
      push       = completing && !m_req_drop && !redirect;
      if (redirect) begin
         m_fifo.delete();
         m_cur_pc = rpc;
`ifdef FETCH_MISALIGN_TRAP_EN
         m_trap = (rpc[1:0] != 2'b00);
`endif
      end else begin
         if (pop) begin
            $display("POP  pc=%h data=%h", m_fifo[0][63:32], m_fifo[0][31:0]);
            void'(m_fifo.pop_front());
         end
         if (push) begin
            m_fifo.push_back({m_req_addr, imemData});
            m_cur_pc = m_cur_pc + 32'd4;
         end
      end
      if (m_req_act && !completing) begin
         if (redirect) m_req_drop = 1'b1;
      end else if (!m_trap && m_fifo.size() < DEPTH) begin
         m_req_act  = 1'b1;
         m_req_addr = m_cur_pc;
         m_req_drop = 1'b0;
      end else begin
         m_req_act = 1'b0;
      end
   endtask

   typedef struct {
      int          cycles;
      int          ack_pct;
      int          ready_pct;
      int          redir_pct;
      logic        force_redir;
      logic [31:0] force_pc;
   } phase_t;

   phase_t phases [9];

   function automatic logic [31:0] pick_target();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return 32'hFFFF_FFF8;
      if (r == 1) return 32'h0000_0102;
      if (r == 2) return $urandom | 32'h1;
      return $urandom & 32'hFFFF_FFFC;
   endfunction

   initial begin
      phases[0] = '{20, 100, 100, 0, 1'b0, 32'h0};
      phases[1] = '{12, 100, 0, 0, 1'b0, 32'h0};
      phases[2] = '{10, 100, 100, 0, 1'b0, 32'h0};
      phases[3] = '{15, 100, 100, 0, 1'b1, 32'hFFFF_FFF8};
      phases[4] = '{600, 60, 60, 8, 1'b0, 32'h0};
      phases[5] = '{600, 40, 80, 20, 1'b0, 32'h0};
      phases[6] = '{300, 90, 30, 10, 1'b0, 32'h0};
      phases[7] = '{10, 100, 100, 0, 1'b1, 32'h0000_0102};
      phases[8] = '{20, 100, 100, 0, 1'b1, 32'h0000_0104};

      Reset      = 1'b0;
      redirect   = 1'b0;
      redirectPC = 32'h0;
      imemAck    = 1'b0;
      imemData   = 32'h0;
      instReady  = 1'b0;
      repeat (3) @(negedge CLK);

      check_eq("rst_imemReq", 32'(imemReq), 32'h0);
      check_eq("rst_imemAddr", imemAddr, 32'h0);
      check_eq("rst_instValid", 32'(instValid), 32'h0);
      check_eq("rst_instPC", instPC, 32'h0);
      check_eq("rst_instData", instData, 32'h0);
      check_eq("rst_curPC", curPC, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check_eq("rst_trap", 32'(misalignTrap), 32'h0);
`endif
      Reset = 1'b1;

      for (int p = 0; p < 9; p++) begin
         for (int c = 0; c < phases[p].cycles; c++) begin
            imemAck   = ($urandom_range(0, 99) < phases[p].ack_pct);
            instReady = ($urandom_range(0, 99) < phases[p].ready_pct);
            imemData  = $urandom;
            if (c == 0 && phases[p].force_redir) begin
               redirect   = 1'b1;
               redirectPC = phases[p].force_pc;
            end else begin
               redirect   = ($urandom_range(0, 99) < phases[p].redir_pct);
               redirectPC = redirect ? pick_target() : $urandom;
            end
            model_step();
            @(negedge CLK);
            cycle++;
            check_outputs();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
